// File: rtl/apb_requester_pkg.sv
// Shared types and default widths for the APB requester.
package apb_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int DEFAULT_AW = 20;
  localparam int DEFAULT_DW = 16;

endpackage

// File: rtl/apb_requester_timer.sv
// Counts consecutive stalled ACCESS cycles; expired pulses on the last allowed one.
module apb_requester_timer #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the CYCLES-th stalled cycle so the FSM leaves ACCESS on that edge.
  assign expired = enable && (count == CW'(CYCLES - 1));

endmodule

// File: rtl/apb_requester.sv
// APB requester: one command in, one APB transfer out, one response back.
// Optional ACCESS watchdog enabled by defining APB_REQUESTER_TIMEOUT_EN.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int AW             = DEFAULT_AW,
  parameter int DW             = DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic            cmd_sel,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_strb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [1:0]      psel,
  output logic            penable,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  output logic            pwrite,
  output logic [DW/8-1:0] pstrb,
  input  logic [DW-1:0]   prdata,
  input  logic            pready,
  input  logic            pslverr
);

  apb_state_t state, state_next;

  logic            sel_q;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] strb_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            timeout;

`ifdef APB_REQUESTER_TIMEOUT_EN
  apb_requester_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state == ACCESS && !pready),
    .clear   (state != ACCESS),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    psel       = 2'b00;
    penable    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        psel       = sel_q ? 2'b10 : 2'b01;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = sel_q ? 2'b10 : 2'b01;
        penable = 1'b1;
        if (pready || timeout) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write data and strobes are zeroed at capture so reads never drive them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        sel_q   <= cmd_sel;
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_write ? cmd_wdata : '0;
        strb_q  <= cmd_write ? cmd_strb : '0;
      end
      if (state == ACCESS) begin
        if (pready) begin
          rdata_q <= write_q ? '0 : prdata;
          err_q   <= pslverr;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester; add APB_REQUESTER_TIMEOUT_EN to also exercise the watchdog.
module tb_apb_requester;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [1:0]    cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [1:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int tests = 0;
  int fails = 0;

  apb_requester #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input logic wr, input logic sel, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] s);
    cmd_write = wr; cmd_sel = sel; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    set_cmd(1'b0, 1'b0, '0, '0, 2'b00);
    #23;
    chk("reset_apb_ctrl", {psel, penable, pwrite}, 4'b0000);
    chk("reset_apb_data", {paddr, pwdata, pstrb}, 38'd0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'd0);
    reset_n = 1'b1;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic test_write_basic();
    set_cmd(1'b1, 1'b0, 20'h00004, 16'h1234, 2'b11);
    cmd_valid = 1'b1; pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("wr_setup_ctrl", {psel, penable, pwrite}, 4'b0101);
    chk("wr_setup_data", {paddr, pwdata, pstrb}, {20'h00004, 16'h1234, 2'b11});
    chk("wr_setup_no_rsp", rsp_valid, 1'b0);
    tick();
    chk("wr_access_ctrl", {psel, penable, pwrite}, 4'b0111);
    chk("wr_access_no_rsp", rsp_valid, 1'b0);
    tick();
    chk("wr_resp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 16'h0000});
    chk("wr_resp_bus_idle", {psel, penable}, 3'b000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_back_idle", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  task automatic test_read_wait();
    set_cmd(1'b0, 1'b1, 20'h00004, 16'hFFFF, 2'b11);
    cmd_valid = 1'b1; pready = 1'b0; prdata = 16'hDEAD;
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_ctrl", {psel, penable, pwrite}, 4'b1000);
    chk("rd_setup_zero_wr", {pwdata, pstrb}, 18'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_ctrl", {psel, penable, pwrite}, 4'b1010);
      chk("rd_wait_data", {paddr, pwdata, pstrb}, {20'h00004, 16'h0000, 2'b00});
      chk("rd_wait_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    chk("rd_still_access", penable, 1'b1);
    pready = 1'b1; prdata = 16'hABCD;
    tick();
    pready = 1'b0; prdata = 16'h0000;
    chk("rd_resp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 16'hABCD});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_back_idle", cmd_ready, 1'b1);
  endtask

  task automatic test_read_err();
    set_cmd(1'b0, 1'b0, 20'h00010, 16'h0000, 2'b00);
    cmd_valid = 1'b1; pready = 1'b1; pslverr = 1'b1; prdata = 16'h5A5A;
    tick();
    chk("err_busy_no_ready", cmd_ready, 1'b0);
    tick();
    tick();
    pslverr = 1'b0; prdata = 16'h0000; pready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("err_resp_hold", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 16'h5A5A});
      chk("err_no_cmd_ready", {cmd_ready, psel, penable}, 4'b0000);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("err_back_idle", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  task automatic test_reset_access();
    set_cmd(1'b1, 1'b1, 20'h00020, 16'h7777, 2'b01);
    cmd_valid = 1'b1; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_pre_access", {psel, penable}, 3'b101);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {psel, penable, pwrite}, 4'b0000);
    chk("rst_async_data", {paddr, pwdata, pstrb}, 38'd0);
    pready = 1'b1;
    #12 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_rsp", {rsp_valid, cmd_ready, psel}, 4'b0100);
    end
    pready = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_cmd(1'b1, 1'b0, 20'h00008, 16'h1111, 2'b01);
    cmd_valid = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    tick();
    chk("b2b_setup1", {psel, penable, paddr}, {3'b010, 20'h00008});
    set_cmd(1'b1, 1'b1, 20'h0000C, 16'h2222, 2'b10);
    tick();
    chk("b2b_access1", {psel, penable, paddr, pwdata}, {3'b011, 20'h00008, 16'h1111});
    tick();
    chk("b2b_resp1", {rsp_valid, psel}, 3'b100);
    tick();
    chk("b2b_idle", {cmd_ready, psel, penable}, 4'b1000);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_setup2", {psel, penable, paddr, pwdata, pstrb}, {3'b100, 20'h0000C, 16'h2222, 2'b10});
    tick();
    chk("b2b_access2", {psel, penable}, 3'b101);
    tick();
    chk("b2b_resp2", {rsp_valid, rsp_err}, 2'b10);
    tick();
    rsp_ready = 1'b0; pready = 1'b0;
    chk("b2b_done", {cmd_ready, rsp_valid}, 2'b10);
  endtask

`ifdef APB_REQUESTER_TIMEOUT_EN
  task automatic test_timeout();
    set_cmd(1'b0, 1'b1, 20'h00040, 16'h0000, 2'b00);
    cmd_valid = 1'b1; pready = 1'b0; prdata = 16'hBEEF;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_waiting", {penable, rsp_valid}, 2'b10);
      tick();
    end
    chk("to_resp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 16'h0000});
    chk("to_bus_dropped", {psel, penable}, 3'b000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_back_idle", cmd_ready, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_read_err();
    test_reset_access();
    test_back_to_back();
`ifdef APB_REQUESTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
